// File: rtl/alu_issue_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU issue arbiter: opcode and condition codes,
// NZCV bit positions, the layout of a packed requester command word and the
// arbiter FSM state encoding.
// Command word layout (33 bits, MSB first):
//   {Opcode[4], Cond[4], SR_Cont[3], SR_Bit[5], S, Immediate[16]}
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  // Compare: updates flags, never writes a result back.
  localparam logic [3:0] OP_CMP = 4'b1011;

  // ARM condition codes.
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside the {N,Z,C,V} nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Command word field offsets and widths.
  localparam int CMD_W       = 33;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 16;
  localparam int S_BIT       = 16;
  localparam int SR_BIT_LSB  = 17;
  localparam int SR_BIT_W    = 5;
  localparam int SR_CONT_LSB = 22;
  localparam int SR_CONT_W   = 3;
  localparam int COND_LSB    = 25;
  localparam int COND_W      = 4;
  localparam int OPC_LSB     = 29;
  localparam int OPC_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic is_cmp(input logic [3:0] opcode);
    return (opcode == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter_if
// Requester and result handshake bundle of the ALU issue arbiter.
//   req_valid/req_ready  per-requester command handshake (ready is one-hot)
//   req_cmd/req_in1/in2  flattened per-requester command word and operands
//   res_*                single registered result channel (valid/ready)
// Modports: master = requesters + result consumer, slave = arbiter.
// -----------------------------------------------------------------------------
interface alu_issue_arbiter_if
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*CMD_W-1:0] req_cmd;
  logic [NUM_REQ*32-1:0]    req_in1;
  logic [NUM_REQ*32-1:0]    req_in2;

  logic                     res_valid;
  logic                     res_ready;
  logic [31:0]              res_data;
  logic [ID_W-1:0]          res_id;
  logic                     res_wb;
  logic                     res_skipped;

  modport master (
    output req_valid, req_cmd, req_in1, req_in2, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_wb, res_skipped
  );

  modport slave (
    input  req_valid, req_cmd, req_in1, req_in2, res_ready,
    output req_ready, res_valid, res_data, res_id, res_wb, res_skipped
  );

endinterface

// File: rtl/alu_issue_arbiter_cond_eval.sv
// -----------------------------------------------------------------------------
// alu_cond_eval
// Combinational ARM condition check: Cond x {N,Z,C,V} -> pass.
// Ports: cond_i (4b condition code), nzcv_i (flags), pass_o (1 = execute).
// Only built with ALU_COND_EXEC_EN; without it commands run unconditionally
// and this module does not exist.
// -----------------------------------------------------------------------------
`ifdef ALU_COND_EXEC_EN
module alu_cond_eval
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = nzcv_i[FLAG_N];
  assign z_s = nzcv_i[FLAG_Z];
  assign c_s = nzcv_i[FLAG_C];
  assign v_s = nzcv_i[FLAG_V];

  // Decode the condition code against the current flags.
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z_s;
      COND_NE: pass_o = !z_s;
      COND_CS: pass_o = c_s;
      COND_CC: pass_o = !c_s;
      COND_MI: pass_o = n_s;
      COND_PL: pass_o = !n_s;
      COND_VS: pass_o = v_s;
      COND_VC: pass_o = !v_s;
      COND_HI: pass_o = c_s && !z_s;
      COND_LS: pass_o = !c_s || z_s;
      COND_GE: pass_o = (n_s == v_s);
      COND_LT: pass_o = (n_s != v_s);
      COND_GT: pass_o = !z_s && (n_s == v_s);
      COND_LE: pass_o = z_s || (n_s != v_s);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule
`endif

// File: rtl/alu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// alu_issue_arbiter
// Shares one combinational ALU between NUM_REQ requesters with round-robin
// arbitration, owns the architectural NZCV register and returns one
// registered result per accepted command.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       requester handshakes + result channel
//   alu_*  (out)      registered ALU operand/control drive
//   alu_out/alu_flags ALU result and {N,Z,C,V}
//   flags_q           architectural NZCV register
// Configuration: ALU_COND_EXEC_EN enables per-command condition evaluation;
// when undefined every command executes and res_skipped is tied 0.
// -----------------------------------------------------------------------------
module alu_issue_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_issue_arbiter_if.slave  bus,
  output logic [31:0]         alu_in1,
  output logic [31:0]         alu_in2,
  output logic [3:0]          alu_opcode,
  output logic [3:0]          alu_cond,
  output logic [4:0]          alu_sr_bit,
  output logic [2:0]          alu_sr_cont,
  output logic                alu_s,
  output logic [15:0]         alu_imm,
  input  logic [31:0]         alu_out,
  input  logic [3:0]          alu_flags,
  output logic [3:0]          flags_q
);

  state_t             state_q;
  logic [ID_W-1:0]    last_grant_q;
  logic [3:0]         nzcv_q;

  // The latched command doubles as the ALU drive registers.
  logic [31:0]        in1_q;
  logic [31:0]        in2_q;
  logic [3:0]         opcode_q;
  logic [3:0]         cond_q;
  logic [4:0]         sr_bit_q;
  logic [2:0]         sr_cont_q;
  logic               s_q;
  logic [15:0]        imm_q;

  logic               res_valid_q;
  logic [31:0]        res_data_q;
  logic [ID_W-1:0]    res_id_q;
  logic               res_wb_q;

  logic               grant_found_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [ID_W-1:0]    probe_idx_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [CMD_W-1:0]   sel_cmd_s;
  logic               pass_s;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    probe_idx_s   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      probe_idx_s = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found_s && bus.req_valid[probe_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = probe_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot ready, only while idle so nothing is granted during EXEC/RESP.
  always_comb begin
    ready_s = '0;
    if ((state_q == ST_IDLE) && grant_found_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign sel_cmd_s = bus.req_cmd[int'(grant_idx_s)*CMD_W +: CMD_W];

`ifdef ALU_COND_EXEC_EN
  logic res_skipped_q;

  alu_cond_eval u_cond_eval (
    .cond_i (cond_q),
    .nzcv_i (nzcv_q),
    .pass_o (pass_s)
  );

  assign bus.res_skipped = res_skipped_q;
`else
  assign pass_s          = 1'b1;
  assign bus.res_skipped = 1'b0;
`endif

  // Arbiter FSM: accept in IDLE, capture ALU result in EXEC, hold in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      nzcv_q        <= 4'b0000;
      in1_q         <= 32'd0;
      in2_q         <= 32'd0;
      opcode_q      <= 4'd0;
      cond_q        <= 4'd0;
      sr_bit_q      <= 5'd0;
      sr_cont_q     <= 3'd0;
      s_q           <= 1'b0;
      imm_q         <= 16'd0;
      res_valid_q   <= 1'b0;
      res_data_q    <= 32'd0;
      res_id_q      <= '0;
      res_wb_q      <= 1'b0;
`ifdef ALU_COND_EXEC_EN
      res_skipped_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_found_s) begin
            opcode_q     <= sel_cmd_s[OPC_LSB +: OPC_W];
            cond_q       <= sel_cmd_s[COND_LSB +: COND_W];
            sr_cont_q    <= sel_cmd_s[SR_CONT_LSB +: SR_CONT_W];
            sr_bit_q     <= sel_cmd_s[SR_BIT_LSB +: SR_BIT_W];
            s_q          <= sel_cmd_s[S_BIT];
            imm_q        <= sel_cmd_s[IMM_LSB +: IMM_W];
            in1_q        <= bus.req_in1[int'(grant_idx_s)*32 +: 32];
            in2_q        <= bus.req_in2[int'(grant_idx_s)*32 +: 32];
            last_grant_q <= grant_idx_s;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // last_grant_q still names the requester of the in-flight command.
          res_id_q    <= last_grant_q;
          res_valid_q <= 1'b1;
          if (pass_s) begin
            res_data_q <= alu_out;
            res_wb_q   <= !is_cmp(opcode_q);
            if (s_q || is_cmp(opcode_q)) begin
              nzcv_q <= alu_flags;
            end
`ifdef ALU_COND_EXEC_EN
            res_skipped_q <= 1'b0;
`endif
          end else begin
            res_data_q <= 32'd0;
            res_wb_q   <= 1'b0;
`ifdef ALU_COND_EXEC_EN
            res_skipped_q <= 1'b1;
`endif
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_wb    = res_wb_q;

  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_opcode  = opcode_q;
  assign alu_cond    = cond_q;
  assign alu_sr_bit  = sr_bit_q;
  assign alu_sr_cont = sr_cont_q;
  assign alu_s       = s_q;
  assign alu_imm     = imm_q;
  assign flags_q     = nzcv_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
`timescale 1ns/1ps
module tb_alu_issue_arbiter;
  import alu_ctrl_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam logic [3:0] OP_ADD = 4'b0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_opcode, alu_cond, alu_flags, flags_q;
  logic [4:0]  alu_sr_bit;
  logic [2:0]  alu_sr_cont;
  logic        alu_s;
  logic [15:0] alu_imm;
  logic [32:0] wide_s;
  logic        ovf_s;

  int checks = 0;
  int errors = 0;

  alu_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  alu_issue_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_opcode  (alu_opcode),
    .alu_cond    (alu_cond),
    .alu_sr_bit  (alu_sr_bit),
    .alu_sr_cont (alu_sr_cont),
    .alu_s       (alu_s),
    .alu_imm     (alu_imm),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .flags_q     (flags_q)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: CMP subtracts (ARM carry = no borrow), everything else adds.
  always_comb begin
    wide_s = 33'd0;
    ovf_s  = 1'b0;
    if (alu_opcode == OP_CMP) begin
      wide_s = {1'b0, alu_in1} + {1'b0, ~alu_in2} + 33'd1;
      ovf_s  = (alu_in1[31] != alu_in2[31]) && (wide_s[31] != alu_in1[31]);
    end else begin
      wide_s = {1'b0, alu_in1} + {1'b0, alu_in2};
      ovf_s  = (alu_in1[31] == alu_in2[31]) && (wide_s[31] != alu_in1[31]);
    end
    alu_out   = wide_s[31:0];
    alu_flags = {wide_s[31], (wide_s[31:0] == 32'd0), wide_s[32], ovf_s};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk(input logic [3:0] op, input logic [3:0] cond, input logic s);
    return {op, cond, 3'b101, 5'b10011, s, 16'hA5C3};
  endfunction

  task automatic drive_req(input int idx, input logic [3:0] op, input logic [3:0] cond,
                           input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.req_cmd[idx*CMD_W +: CMD_W] = mk(op, cond, s);
    bus.req_in1[idx*32 +: 32]       = a;
    bus.req_in2[idx*32 +: 32]       = b;
    bus.req_valid[idx]              = 1'b1;
  endtask

  // Issue one command from a lone requester and walk it to RESP (t+2).
  task automatic run_single(input string tag, input int idx, input logic [3:0] op,
                            input logic [3:0] cond, input logic s,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] exp_ready);
    drive_req(idx, op, cond, s, a, b);
    #1;
    chk({tag, ".ready"}, bus.req_ready, exp_ready);
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk({tag, ".exec_ready"}, bus.req_ready, 2'b00);
    chk({tag, ".exec_valid"}, bus.res_valid, 1'b0);
    chk({tag, ".alu_opcode"}, alu_opcode, op);
    chk({tag, ".alu_cond"}, alu_cond, cond);
    chk({tag, ".alu_in1"}, alu_in1, a);
    chk({tag, ".alu_in2"}, alu_in2, b);
    chk({tag, ".alu_s"}, alu_s, s);
    @(posedge clk); #1;
    chk({tag, ".res_valid"}, bus.res_valid, 1'b1);
  endtask

  task automatic check_res(input string tag, input logic [31:0] data, input logic wb,
                           input logic skipped, input logic id, input logic [3:0] fl);
    chk({tag, ".res_data"}, bus.res_data, data);
    chk({tag, ".res_wb"}, bus.res_wb, wb);
    chk({tag, ".res_skipped"}, bus.res_skipped, skipped);
    chk({tag, ".res_id"}, bus.res_id, id);
    chk({tag, ".flags"}, flags_q, fl);
  endtask

  task automatic release_resp(input string tag);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({tag, ".released"}, bus.res_valid, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.res_valid", bus.res_valid, 1'b0);
    chk("rst.flags", flags_q, 4'b0000);
    chk("rst.req_ready", bus.req_ready, 2'b00);
    chk("rst.alu_opcode", alu_opcode, 4'b0000);
    chk("rst.res_data", bus.res_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: CMP 15 vs 20 -> N set, no write-back; static fields pass through.
    run_single("s1", 0, OP_CMP, COND_AL, 1'b0, 32'd15, 32'd20, 2'b01);
    check_res("s1", 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0, 4'b1000);
    chk("s1.alu_imm", alu_imm, 16'hA5C3);
    chk("s1.alu_sr_bit", alu_sr_bit, 5'b10011);
    chk("s1.alu_sr_cont", alu_sr_cont, 3'b101);
    release_resp("s1");

    // 2: back-to-back CMPs; the second sees the first's flags already in place.
    run_single("s2a", 0, OP_CMP, COND_AL, 1'b0, 32'd5, 32'd5, 2'b01);
    check_res("s2a", 32'd0, 1'b0, 1'b0, 1'b0, 4'b0110);
    release_resp("s2a");
    run_single("s2b", 0, OP_CMP, COND_AL, 1'b0, 32'd30, 32'd25, 2'b01);
    check_res("s2b", 32'd5, 1'b0, 1'b0, 1'b0, 4'b0010);
    release_resp("s2b");

    // 3: Z=1 then NE / EQ / NV, then an S=1 ADD overflowing from req1.
    run_single("s3z", 0, OP_CMP, COND_AL, 1'b0, 32'd7, 32'd7, 2'b01);
    check_res("s3z", 32'd0, 1'b0, 1'b0, 1'b0, 4'b0110);
    release_resp("s3z");
    run_single("s3ne", 0, OP_ADD, COND_NE, 1'b0, 32'd1, 32'd2, 2'b01);
`ifdef ALU_COND_EXEC_EN
    check_res("s3ne", 32'd0, 1'b0, 1'b1, 1'b0, 4'b0110);
`else
    check_res("s3ne", 32'd3, 1'b1, 1'b0, 1'b0, 4'b0110);
`endif
    release_resp("s3ne");
    run_single("s3eq", 0, OP_ADD, COND_EQ, 1'b0, 32'd1, 32'd2, 2'b01);
    check_res("s3eq", 32'd3, 1'b1, 1'b0, 1'b0, 4'b0110);
    release_resp("s3eq");
    run_single("s3nv", 0, OP_ADD, COND_NV, 1'b0, 32'd4, 32'd4, 2'b01);
`ifdef ALU_COND_EXEC_EN
    check_res("s3nv", 32'd0, 1'b0, 1'b1, 1'b0, 4'b0110);
`else
    check_res("s3nv", 32'd8, 1'b1, 1'b0, 1'b0, 4'b0110);
`endif
    release_resp("s3nv");
    run_single("s3s", 1, OP_ADD, COND_AL, 1'b1, 32'h7FFF_FFFF, 32'd1, 2'b10);
    check_res("s3s", 32'h8000_0000, 1'b1, 1'b0, 1'b1, 4'b1001);
    release_resp("s3s");

    // 4: both requesters always valid, consumer always ready -> 0,1,0,1.
    drive_req(0, OP_ADD, COND_AL, 1'b0, 32'd100, 32'd0);
    drive_req(1, OP_ADD, COND_AL, 1'b0, 32'd200, 32'd0);
    bus.res_ready = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("s4.grant", bus.req_ready, (g % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      chk("s4.exec_ready", bus.req_ready, 2'b00);
      @(posedge clk); #1;
      chk("s4.res_valid", bus.res_valid, 1'b1);
      chk("s4.res_id", bus.res_id, (g % 2 == 0) ? 1'b0 : 1'b1);
      chk("s4.res_data", bus.res_data, (g % 2 == 0) ? 32'd100 : 32'd200);
      chk("s4.resp_ready", bus.req_ready, 2'b00);
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b0;

    // 5: consumer stalls 5 cycles in RESP; outputs hold, nothing granted.
    drive_req(0, OP_ADD, COND_AL, 1'b0, 32'd9, 32'd1);
    drive_req(1, OP_ADD, COND_AL, 1'b0, 32'd200, 32'd0);
    #1;
    chk("s5.grant", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("s5.hold_valid", bus.res_valid, 1'b1);
      chk("s5.hold_data", bus.res_data, 32'd10);
      chk("s5.hold_id", bus.res_id, 1'b0);
      chk("s5.hold_ready", bus.req_ready, 2'b00);
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    release_resp("s5");

    // 6: reset while a CMP sits in EXEC -> dropped, flags cleared.
    run_single("s6", 1, OP_CMP, COND_AL, 1'b0, 32'd1, 32'd2, 2'b10);
    release_resp("s6pre");
    drive_req(1, OP_CMP, COND_AL, 1'b0, 32'd3, 32'd4);
    #1;
    chk("s6.grant", bus.req_ready, 2'b10);
    @(posedge clk); #1;
    chk("s6.in_exec", alu_opcode, OP_CMP);
    rst           = 1'b1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    chk("s6.res_valid", bus.res_valid, 1'b0);
    chk("s6.flags", flags_q, 4'b0000);
    chk("s6.alu_opcode", alu_opcode, 4'b0000);
    chk("s6.alu_in1", alu_in1, 32'd0);
    chk("s6.res_data", bus.res_data, 32'd0);
    chk("s6.res_id", bus.res_id, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("s6.no_result", bus.res_valid, 1'b0);
    // Round-robin pointer is back at NUM_REQ-1, so req0 wins.
    drive_req(0, OP_ADD, COND_AL, 1'b0, 32'd1, 32'd1);
    drive_req(1, OP_ADD, COND_AL, 1'b0, 32'd1, 32'd1);
    #1;
    chk("s6.rr_reset", bus.req_ready, 2'b01);
    bus.req_valid = '0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
